// File: rtl/cpu_fpu_int_to_float_pkg.sv
// Shared FPU definitions: binary32 field layout, exponent bias and the
// state encoding used by the iterative conversion units.
package cpu_fpu_int_to_float_pkg;

   localparam int FP32_BIAS     = 127;
   localparam int FP32_SIGN_BIT = 31;
   localparam int FP32_EXP_MSB  = 30;
   localparam int FP32_EXP_LSB  = 23;
   localparam int FP32_MANT_MSB = 22;
   localparam int FP32_MANT_LSB = 0;

   typedef enum logic [2:0] {
      CVT_IDLE  = 3'd0,
      CVT_CHECK = 3'd1,
      CVT_NORM  = 3'd2,
      CVT_ROUND = 3'd3,
      CVT_DONE  = 3'd4
   } fpu_cvt_state_t;

endpackage

// File: rtl/cpu_fpu_int_to_float_round_pack.sv
// Round-to-nearest-even and binary32 field packing for a normalised
// magnitude whose leading one sits just above frac[30]. The leading one
// itself is implicit, so only the bits below it are taken.
module fpu_round_pack
   import cpu_fpu_int_to_float_pkg::*;
(
   input  logic        sign,
   input  logic [5:0]  exp,
   input  logic [30:0] frac,
   output logic [31:0] result
);

   logic [22:0] mant;
   logic [7:0]  exp_biased;
   logic        guard;
   logic        sticky;
   logic        round_up;

   // Round the 23 kept bits on guard/sticky, carrying into the exponent
   // when the mantissa wraps, then pack the three fields.
   always_comb begin
      mant       = frac[30:8];
      guard      = frac[7];
      sticky     = |frac[6:0];
      round_up   = guard & (sticky | mant[0]);
      exp_biased = {2'b00, exp} + 8'(FP32_BIAS);
      if (round_up && (&mant)) begin
         mant       = '0;
         exp_biased = exp_biased + 8'd1;
      end else if (round_up) begin
         mant = mant + 23'd1;
      end
      result                              = '0;
      result[FP32_SIGN_BIT]               = sign;
      result[FP32_EXP_MSB:FP32_EXP_LSB]   = exp_biased;
      result[FP32_MANT_MSB:FP32_MANT_LSB] = mant;
   end

endmodule

// File: rtl/cpu_fpu_int_to_float.sv
// Multi-cycle integer to binary32 converter (FCVT.S.W / FCVT.S.WU).
// The magnitude is normalised one bit per cycle, so latency depends on
// the number of leading zeros rather than needing a priority encoder.
module cpu_fpu_int_to_float
   import cpu_fpu_int_to_float_pkg::*;
(
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   input  logic [31:0] i_op1,
   input  logic        i_signed,
   output logic        o_ready,
   output logic [31:0] o_result
);

   fpu_cvt_state_t state;
   fpu_cvt_state_t state_next;

   logic        sign;
   logic [31:0] mag;
   logic [5:0]  exp;
   logic [31:0] z;
   logic [31:0] packed_result;
   logic        op_negative;

   assign op_negative = i_signed & i_op1[31];

   fpu_round_pack u_round_pack (
      .sign   (sign),
      .exp    (exp),
      .frac   (mag[30:0]),
      .result (packed_result)
   );

   // State register; reset abandons any conversion in flight.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= CVT_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state sequencing through check, normalise, round and handshake.
   always_comb begin
      state_next = state;
      case (state)
         CVT_IDLE:  if (i_request) state_next = CVT_CHECK;
         CVT_CHECK: state_next = (mag == 32'd0) ? CVT_DONE : CVT_NORM;
         CVT_NORM:  if (mag[31]) state_next = CVT_ROUND;
         CVT_ROUND: state_next = CVT_DONE;
         CVT_DONE:  if (!i_request) state_next = CVT_IDLE;
         default:   state_next = CVT_IDLE;
      endcase
   end

   // Datapath and registered outputs; the operand is captured only in IDLE.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_ready  <= 1'b0;
         o_result <= 32'd0;
         sign     <= 1'b0;
         mag      <= 32'd0;
         exp      <= 6'd0;
         z        <= 32'd0;
      end else begin
         case (state)
            CVT_IDLE: begin
               o_ready <= 1'b0;
               if (i_request) begin
                  sign <= op_negative;
                  mag  <= op_negative ? (~i_op1 + 32'd1) : i_op1;
               end
            end
            CVT_CHECK: begin
               if (mag == 32'd0) begin
                  z <= 32'd0;
               end else begin
                  exp <= 6'd31;
               end
            end
            CVT_NORM: begin
               if (!mag[31]) begin
                  mag <= mag << 1;
                  exp <= exp - 6'd1;
               end
            end
            CVT_ROUND: begin
               z <= packed_result;
            end
            CVT_DONE: begin
               o_result <= z;
               o_ready  <= i_request;
            end
            default: begin
               o_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_fpu_int_to_float.sv
// Directed-vector bench for the integer to binary32 converter.
module tb_cpu_fpu_int_to_float;

   logic        i_clock;
   logic        i_reset;
   logic        i_request;
   logic [31:0] i_op1;
   logic        i_signed;
   logic        o_ready;
   logic [31:0] o_result;

   int checks;
   int failures;

   cpu_fpu_int_to_float dut (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_request (i_request),
      .i_op1     (i_op1),
      .i_signed  (i_signed),
      .o_ready   (o_ready),
      .o_result  (o_result)
   );

   // Free-running 10 ns clock.
   initial begin
      i_clock = 1'b0;
      forever #5 i_clock = ~i_clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Issue one conversion, measure latency, optionally hold the request,
   // then release it and confirm o_ready drops on the next edge.
   task automatic applyStimulus(input string tag, input logic [31:0] op,
                                input logic sgn, input logic [31:0] exp_res,
                                input int exp_lat, input int hold_cycles);
      int lat;
      bit seen;
      @(negedge i_clock);
      i_request = 1'b1;
      i_op1     = op;
      i_signed  = sgn;
      @(posedge i_clock);
      lat  = 0;
      seen = 0;
      while (!seen && lat < 60) begin
         @(posedge i_clock);
         #1;
         lat++;
         if (o_ready) seen = 1;
      end
      checkOutput({tag, "_ready_timeout"}, 32'(seen), 32'd1);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, "_result"}, o_result, exp_res);
      // Operand changes after acceptance must not matter.
      @(negedge i_clock);
      i_op1    = 32'h1234_5678;
      i_signed = ~sgn;
      for (int k = 0; k < hold_cycles; k++) begin
         @(posedge i_clock);
         #1;
         checkOutput({tag, "_hold_ready"}, 32'(o_ready), 32'd1);
         checkOutput({tag, "_hold_result"}, o_result, exp_res);
      end
      @(negedge i_clock);
      i_request = 1'b0;
      @(posedge i_clock);
      #1;
      checkOutput({tag, "_release_ready"}, 32'(o_ready), 32'd0);
   endtask

   initial begin
      int pulses;
      checks    = 0;
      failures  = 0;
      i_reset   = 1'b1;
      i_request = 1'b0;
      i_op1     = 32'd0;
      i_signed  = 1'b0;
      repeat (2) @(posedge i_clock);
      #1;
      checkOutput("reset_ready", 32'(o_ready), 32'd0);
      checkOutput("reset_result", o_result, 32'd0);
      @(negedge i_clock);
      i_reset = 1'b0;

      applyStimulus("one_s",      32'h0000_0001, 1'b1, 32'h3F80_0000, 35, 0);
      applyStimulus("m1_s",       32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 35, 0);
      applyStimulus("max_u",      32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 4,  0);
      applyStimulus("min_s",      32'h8000_0000, 1'b1, 32'hCF00_0000, 4,  0);
      applyStimulus("zero_s",     32'h0000_0000, 1'b1, 32'h0000_0000, 2,  0);
      applyStimulus("tie_even",   32'h0100_0001, 1'b0, 32'h4B80_0000, 11, 0);
      applyStimulus("tie_odd",    32'h0100_0003, 1'b0, 32'h4B80_0002, 11, 0);
      applyStimulus("max_s",      32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 5,  0);
      applyStimulus("m5_s",       32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 33, 0);
      applyStimulus("hold",       32'h0000_0003, 1'b0, 32'h4040_0000, 34, 10);
      applyStimulus("rereq",      32'h0000_0002, 1'b0, 32'h4000_0000, 34, 0);

      // Reset in the middle of normalisation clears the outputs.
      @(negedge i_clock);
      i_request = 1'b1;
      i_op1     = 32'h0000_0001;
      i_signed  = 1'b0;
      repeat (6) @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b1;
      @(posedge i_clock);
      #1;
      checkOutput("midreset_ready", 32'(o_ready), 32'd0);
      checkOutput("midreset_result", o_result, 32'd0);
      @(negedge i_clock);
      i_reset   = 1'b0;
      i_request = 1'b0;
      applyStimulus("after_reset", 32'h0000_0005, 1'b0, 32'h40A0_0000, 33, 0);

      // Withdrawn request: conversion finishes silently and returns to IDLE.
      @(negedge i_clock);
      i_request = 1'b1;
      i_op1     = 32'h0000_0001;
      i_signed  = 1'b0;
      repeat (4) @(posedge i_clock);
      @(negedge i_clock);
      i_request = 1'b0;
      pulses = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge i_clock);
         #1;
         if (o_ready) pulses++;
      end
      checkOutput("withdraw_no_pulse", 32'(pulses), 32'd0);
      applyStimulus("after_withdraw", 32'hFFFF_FFFE, 1'b1, 32'hC000_0000, 34, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_fpu_int_to_float.md
Name: cpu_fpu_int_to_float

Overview:
- Multi-cycle integer-to-single-precision converter, serving FCVT.S.W and FCVT.S.WU.
- Sits in the FPU execute stage beside the float-to-int converter and uses the same request/ready handshake.
- Input is a 32-bit integer taken as signed or unsigned; output is an IEEE-754 binary32 rounded to nearest-even.
- Normalisation is iterative, one bit per cycle, so no barrel shifter or priority encoder is needed.

Parameters:
- None. Widths are fixed at 32-bit integer and binary32.

Ports:
- i_clock  input  1  clock, rising edge.
- i_reset  input  1  reset, synchronous, active-high.
- i_request  input  1  conversion request; held high until the result is consumed.
- i_op1  input  32  integer operand.
- i_signed  input  1  1 = treat i_op1 as two's complement, 0 = unsigned.
- o_ready  output  1  result valid.
- o_result  output  32  binary32 result, registered.

Behaviour:
- Reset (i_reset sampled high):
  - state <= IDLE, o_ready <= 0, o_result <= 0.
  - Reset overrides all other assignments in that cycle.
  - Any conversion in flight is abandoned with no output.
- Internal registers:
  - sign (1 bit), mag (32 bits unsigned), exp (6 bits, unbiased, range 0..32), z (32 bits).
- IDLE:
  - o_ready <= 0.
  - If i_request: sign <= i_signed & i_op1[31]; mag <= sign ? -i_op1 : i_op1 (32-bit wrap); go to CHECK.
  - -2^31 gives mag = 0x80000000 and is handled correctly.
  - i_op1 and i_signed are sampled only here. Later changes to them are ignored.
- CHECK:
  - If mag == 0: z <= 0x00000000 (+0 even for signed input), go to DONE.
  - Else: exp <= 31, go to NORM.
- NORM:
  - If mag[31] == 0: mag <= mag << 1, exp <= exp - 1, stay in NORM.
  - Else go to ROUND.
- ROUND:
  - mant = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - up = guard & (sticky | mant[0]).
  - If up and mant == all ones: mant <= 0 and exp <= exp + 1 (carry-out).
  - Else if up: mant <= mant + 1.
  - z <= {sign, exp + 127 (8 bits), mant}, then go to DONE.
  - Overflow is impossible (max biased exponent 159). No denormals, infinities or NaNs are produced.
- DONE:
  - o_ready <= 1, o_result <= z.
  - If !i_request in the same cycle: o_ready <= 0 (overrides the set, so no spurious pulse), go to IDLE.
  - Else stay in DONE; o_ready and o_result hold.
- Latency, counted from the edge that samples i_request high in IDLE to the edge where o_ready rises:
  - Non-zero operand: lz + 4 cycles, where lz = leading zeros of mag (0..31). Range is 4..35.
  - Zero operand: 2 cycles.
- Back-to-back: a new request is accepted only from IDLE. i_request must drop for at least one cycle between conversions.
- Request withdrawn mid-conversion: the conversion runs to DONE, then returns to IDLE without asserting o_ready.
- Undefined state encodings: go to IDLE.

Decomposition:
- Shared FPU package:
  - FP32_BIAS = 127.
  - Field position constants: sign bit 31, exponent 30:23, mantissa 22:0.
  - State enum for the conversion units.
- Optional sub-module fpu_round_pack: combinational round-to-nearest-even plus field packing from {sign, exp, 32-bit normalised mag}.
  - Reusable by the adder and multiplier packing stages.
  - Otherwise the block is a single module.

Test Plan:
- i_op1 = 0x00000001, i_signed = 1 -> o_result = 0x3F800000; o_ready rises 35 cycles after request.
- i_op1 = 0xFFFFFFFF with i_signed = 1 -> 0xBF800000; same operand with i_signed = 0 -> 0x4F800000 (round-up carry-out); latency 4.
- i_op1 = 0x80000000, i_signed = 1 -> 0xCF000000; i_op1 = 0x00000000, i_signed = 1 -> 0x00000000 with latency 2.
- Ties, unsigned:
  - 0x01000001 -> 0x4B800000 (tie, even mantissa, no round-up).
  - 0x01000003 -> 0x4B800002 (tie, odd mantissa, round up).
- Handshake: hold i_request 10 extra cycles after o_ready -> o_ready and o_result stable; drop i_request -> o_ready low the next cycle; re-request 0x00000002 -> 0x40000000.
- Interruptions:
  - Assert i_reset during NORM -> o_ready = 0 and o_result = 0 next cycle; the next request converts correctly.
  - Drop i_request during NORM -> o_ready never pulses and the block returns to IDLE.
